lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, RV32I access-size encodings, response error codes
// and the acceptance-time legality checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] is the access size; funct3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic is_illegal(input logic [2:0] f3, input logic is_store);
        return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (is_store && f3[2]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == SZ_H) && a[0]) || ((f3[1:0] == SZ_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data replication and load lane extraction with
// sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sext;

    always_comb begin
        wstrb = 4'b1111;
        wdata = st_data;
        case (funct3[1:0])
            SZ_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        sext    = ~funct3[2];
        case (funct3[1:0])
            SZ_B:    ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{sext & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accepts one request, issues one word-aligned
// memory access with a bounded wait for ack, and returns a one-cycle response.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          store_q, store_d;
    logic          req_ready_q, req_ready_d;
    logic          mem_req_q, mem_req_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    err_e          rsp_err_q, rsp_err_d;

    logic          accept;
    logic [3:0]    al_wstrb;
    logic [31:0]   al_wdata;
    logic [31:0]   al_ld;

    lsu_align u_align (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (mem_rdata),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    assign accept = req_valid & req_ready_q & (req_is_load ^ req_is_store);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        store_d     = store_q;
        req_ready_d = req_ready_q;
        mem_req_d   = mem_req_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = ERR_OK;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    f3_d        = req_funct3;
                    store_d     = req_is_store;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    // Bad requests skip memory entirely and respond next cycle
                    if (is_illegal(req_funct3, req_is_store)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_ILLEGAL;
                    end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_MISALIGN;
                    end else begin
                        state_d   = ST_REQ;
                        mem_req_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = store_q ? 32'd0 : al_ld;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            store_q     <= 1'b0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            store_q     <= store_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory-side fields are forced to zero whenever no access is in flight
    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & store_q;
    assign mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wstrb = (mem_req_q & store_q) ? al_wstrb : 4'b0000;
    assign mem_wdata = (mem_req_q & store_q) ? al_wdata : 32'd0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
